// File: rtl/mem_stage.sv
// MEM pipeline stage: tracks the outstanding data-SRAM access, buffers rdata under WB stall,
// extracts/extends load data and discards responses of flushed instructions. Option: MS_LOAD_FWD_EN.
module mem_stage #(
    parameter int DROP_CNT_W = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic        es_req_issued,
    input  logic [31:0] es_pc,
    input  logic [4:0]  es_ld_inst,
    input  logic        es_rf_we,
    input  logic [4:0]  es_rf_waddr,
    input  logic [31:0] es_result,
    input  logic [86:0] es_ex_zip,
    input  logic [9:0]  es2ms_tlb_zip,
    input  logic [7:0]  es2ms_tlb_exc,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    input  logic        wb_ex,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic        ms_rf_we,
    output logic [4:0]  ms_rf_waddr,
    output logic [31:0] ms_final_result,
    output logic        ms_ex,
    output logic [86:0] ms_ex_zip,
    output logic [9:0]  ms2ws_tlb_zip,
    output logic [7:0]  ms2ws_tlb_exc,
    output logic        ms_fwd_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state;
    logic                  ms_valid;
    logic [DROP_CNT_W-1:0] drop_cnt;
    logic [4:0]            ms_ld_inst;
    logic                  ms_rf_we_r;
    logic [31:0]           ms_result;
    logic [31:0]           rbuf;

    logic data_ok_eff;
    logic ms_ready_go;
    logic accept;
    logic drop_inc;
    logic drop_dec;
    logic is_load;

    // Responses still owed to flushed instructions are swallowed before any new one counts.
    assign data_ok_eff = data_sram_data_ok & (drop_cnt == '0);
    assign drop_dec    = data_sram_data_ok & (drop_cnt != '0);
    assign drop_inc    = wb_ex & (state == S_WAIT) & ~data_ok_eff;

    assign ms_ready_go    = (state != S_WAIT) | data_ok_eff;
    assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;
    assign accept         = es_to_ms_valid & ms_allowin & ~wb_ex;

    assign is_load  = |ms_ld_inst;
    assign ms_ex    = ((|ms_ex_zip[7:0]) | (|ms2ws_tlb_exc)) & ms_valid;
    assign ms_rf_we = ms_rf_we_r & ms_valid & ~ms_ex;

`ifdef MS_LOAD_FWD_EN
    assign ms_fwd_valid = ms_valid & ms_rf_we & (~is_load | ms_ready_go);
`else
    assign ms_fwd_valid = ms_valid & ms_rf_we & ~is_load;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid      <= 1'b0;
            state         <= S_IDLE;
            drop_cnt      <= '0;
            ms_pc         <= '0;
            ms_ld_inst    <= '0;
            ms_rf_we_r    <= 1'b0;
            ms_rf_waddr   <= '0;
            ms_result     <= '0;
            ms_ex_zip     <= '0;
            ms2ws_tlb_zip <= '0;
            ms2ws_tlb_exc <= '0;
            rbuf          <= '0;
        end else begin
            if (wb_ex)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;

            if (accept) begin
                ms_pc         <= es_pc;
                ms_ld_inst    <= es_ld_inst;
                ms_rf_we_r    <= es_rf_we;
                ms_rf_waddr   <= es_rf_waddr;
                ms_result     <= es_result;
                ms_ex_zip     <= es_ex_zip;
                ms2ws_tlb_zip <= es2ms_tlb_zip;
                ms2ws_tlb_exc <= es2ms_tlb_exc;
            end

            // A newly accepted instruction overrides whatever the leaving transition would pick.
            if (wb_ex) begin
                state <= S_IDLE;
            end else if (accept) begin
                state <= es_req_issued ? S_WAIT : S_IDLE;
            end else begin
                unique case (state)
                    S_WAIT: begin
                        if (data_ok_eff) begin
                            if (ws_allowin) begin
                                state <= S_IDLE;
                            end else begin
                                state <= S_DONE;
                                rbuf  <= data_sram_rdata;
                            end
                        end
                    end
                    S_DONE:  if (ws_allowin) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end

            if (drop_inc && !drop_dec) begin
                if (drop_cnt != '1)
                    drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end else if (drop_dec && !drop_inc) begin
                drop_cnt <= drop_cnt - DROP_CNT_W'(1);
            end
        end
    end

    drop_cnt_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(drop_inc && !drop_dec && (drop_cnt == '1)));

    logic [31:0] ld_src;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ld_src          = (state == S_DONE) ? rbuf : data_sram_rdata;
        ld_half         = ms_result[1] ? ld_src[31:16] : ld_src[15:0];
        ld_byte         = ld_src[7:0];
        ms_final_result = ms_result;
        unique case (ms_result[1:0])
            2'd0: ld_byte = ld_src[7:0];
            2'd1: ld_byte = ld_src[15:8];
            2'd2: ld_byte = ld_src[23:16];
            2'd3: ld_byte = ld_src[31:24];
        endcase
        if (ms_ld_inst[4])
            ms_final_result = {{24{ld_byte[7]}}, ld_byte};
        else if (ms_ld_inst[3])
            ms_final_result = {24'd0, ld_byte};
        else if (ms_ld_inst[2])
            ms_final_result = {{16{ld_half[15]}}, ld_half};
        else if (ms_ld_inst[1])
            ms_final_result = {16'd0, ld_half};
        else if (ms_ld_inst[0])
            ms_final_result = ld_src;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: load extension, WB stall buffering,
// flush/discard bookkeeping, back-to-back issue and asynchronous reset.
module tb_mem_stage;

    localparam bit FWD_LOAD =
`ifdef MS_LOAD_FWD_EN
        1'b1;
`else
        1'b0;
`endif

    localparam logic [4:0] LD_B  = 5'b10000;
    localparam logic [4:0] LD_BU = 5'b01000;
    localparam logic [4:0] LD_H  = 5'b00100;
    localparam logic [4:0] LD_HU = 5'b00010;
    localparam logic [4:0] LD_W  = 5'b00001;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic        es_req_issued;
    logic [31:0] es_pc;
    logic [4:0]  es_ld_inst;
    logic        es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic [31:0] es_result;
    logic [86:0] es_ex_zip;
    logic [9:0]  es2ms_tlb_zip;
    logic [7:0]  es2ms_tlb_exc;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        wb_ex;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_final_result;
    logic        ms_ex;
    logic [86:0] ms_ex_zip;
    logic [9:0]  ms2ws_tlb_zip;
    logic [7:0]  ms2ws_tlb_exc;
    logic        ms_fwd_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allowin        (ms_allowin),
        .es_req_issued     (es_req_issued),
        .es_pc             (es_pc),
        .es_ld_inst        (es_ld_inst),
        .es_rf_we          (es_rf_we),
        .es_rf_waddr       (es_rf_waddr),
        .es_result         (es_result),
        .es_ex_zip         (es_ex_zip),
        .es2ms_tlb_zip     (es2ms_tlb_zip),
        .es2ms_tlb_exc     (es2ms_tlb_exc),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allowin        (ws_allowin),
        .wb_ex             (wb_ex),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_rf_we          (ms_rf_we),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_final_result   (ms_final_result),
        .ms_ex             (ms_ex),
        .ms_ex_zip         (ms_ex_zip),
        .ms2ws_tlb_zip     (ms2ws_tlb_zip),
        .ms2ws_tlb_exc     (ms2ws_tlb_exc),
        .ms_fwd_valid      (ms_fwd_valid)
    );

    // Advance to 1 time unit after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling, well before the next edge.
    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        es_to_ms_valid    = 1'b0;
        es_req_issued     = 1'b0;
        es_pc             = '0;
        es_ld_inst        = '0;
        es_rf_we          = 1'b0;
        es_rf_waddr       = '0;
        es_result         = '0;
        es_ex_zip         = '0;
        es2ms_tlb_zip     = '0;
        es2ms_tlb_exc     = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        wb_ex             = 1'b0;
    endtask

    task automatic present(input logic [31:0] pc, input logic [4:0] ld,
                           input logic [31:0] res, input logic req);
        es_to_ms_valid = 1'b1;
        es_req_issued  = req;
        es_pc          = pc;
        es_ld_inst     = ld;
        es_rf_we       = 1'b1;
        es_rf_waddr    = 5'd7;
        es_result      = res;
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        ws_allowin = 1'b1;
        idle_inputs();
        repeat (3) cyc();
        resetn = 1'b1;
        settle();
        checks++; if (ms_to_ws_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", ms_to_ws_valid); failures++; end
        checks++; if (ms_allowin !== 1'b1) begin $display("FAIL reset_allowin got=%b exp=1", ms_allowin); failures++; end
        checks++; if (ms_final_result !== 32'h0) begin $display("FAIL reset_result got=%h exp=0", ms_final_result); failures++; end
        checks++; if (ms_pc !== 32'h0) begin $display("FAIL reset_pc got=%h exp=0", ms_pc); failures++; end
        checks++; if (ms_fwd_valid !== 1'b0) begin $display("FAIL reset_fwd got=%b exp=0", ms_fwd_valid); failures++; end
        checks++; if (dut.drop_cnt !== 2'd0) begin $display("FAIL reset_drop got=%0d exp=0", dut.drop_cnt); failures++; end
    endtask

    task automatic test_load_word();
        cyc();
        present(32'h0000_0100, LD_W, 32'h0000_1000, 1'b1);
        settle();
        checks++; if (ms_allowin !== 1'b1) begin $display("FAIL ldw_allowin_empty got=%b exp=1", ms_allowin); failures++; end
        cyc();
        idle_inputs();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8877_6655;
        settle();
        checks++; if (ms_to_ws_valid !== 1'b1) begin $display("FAIL ldw_valid got=%b exp=1", ms_to_ws_valid); failures++; end
        checks++; if (ms_final_result !== 32'h8877_6655) begin $display("FAIL ldw_result got=%h exp=88776655", ms_final_result); failures++; end
        checks++; if (ms_pc !== 32'h0000_0100) begin $display("FAIL ldw_pc got=%h exp=00000100", ms_pc); failures++; end
        checks++; if (ms_rf_we !== 1'b1 || ms_rf_waddr !== 5'd7) begin $display("FAIL ldw_rf got=%b/%0d exp=1/7", ms_rf_we, ms_rf_waddr); failures++; end
        checks++; if (ms_fwd_valid !== FWD_LOAD) begin $display("FAIL ldw_fwd got=%b exp=%b", ms_fwd_valid, FWD_LOAD); failures++; end
        cyc();
        idle_inputs();
        settle();
        checks++; if (ms_to_ws_valid !== 1'b0) begin $display("FAIL ldw_retired got=%b exp=0", ms_to_ws_valid); failures++; end
    endtask

    task automatic test_load_ext();
        logic [4:0]  ld_t  [6] = '{LD_B, LD_BU, LD_HU, LD_H, LD_B, LD_H};
        logic [31:0] adr_t [6] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1001, 32'h1002};
        logic [31:0] dat_t [6] = '{32'h8012_3456, 32'h8012_3456, 32'hBEEF_1234,
                                   32'h1234_8001, 32'h0000_7F00, 32'h7FFE_0000};
        logic [31:0] exp_t [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF,
                                   32'hFFFF_8001, 32'h0000_007F, 32'h0000_7FFE};
        for (int i = 0; i < 6; i++) begin
            cyc();
            present(32'h0000_0200 + 32'(i * 4), ld_t[i], adr_t[i], 1'b1);
            cyc();
            idle_inputs();
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = dat_t[i];
            settle();
            checks++; if (ms_to_ws_valid !== 1'b1) begin $display("FAIL ext%0d_valid got=%b exp=1", i, ms_to_ws_valid); failures++; end
            checks++; if (ms_final_result !== exp_t[i]) begin $display("FAIL ext%0d_result got=%h exp=%h", i, ms_final_result, exp_t[i]); failures++; end
        end
        // Non-load: no SRAM request, result passes straight through and is forwardable.
        cyc();
        idle_inputs();
        present(32'h0000_0300, 5'b00000, 32'hDEAD_BEEF, 1'b0);
        cyc();
        idle_inputs();
        data_sram_rdata = 32'h1234_5678;
        settle();
        checks++; if (ms_to_ws_valid !== 1'b1) begin $display("FAIL alu_valid got=%b exp=1", ms_to_ws_valid); failures++; end
        checks++; if (ms_final_result !== 32'hDEAD_BEEF) begin $display("FAIL alu_result got=%h exp=deadbeef", ms_final_result); failures++; end
        checks++; if (ms_fwd_valid !== 1'b1) begin $display("FAIL alu_fwd got=%b exp=1", ms_fwd_valid); failures++; end
    endtask

    task automatic test_wb_stall();
        cyc();
        idle_inputs();
        ws_allowin = 1'b0;
        present(32'h0000_0400, LD_W, 32'h0000_1000, 1'b1);
        cyc();
        idle_inputs();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        settle();
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin $display("FAIL stall_dataok got=%b/%b exp=1/0", ms_to_ws_valid, ms_allowin); failures++; end
        for (int i = 0; i < 2; i++) begin
            cyc();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 32'h1111_1111;
            settle();
            checks++; if (dut.state !== 2'd2) begin $display("FAIL stall%0d_state got=%0d exp=2", i, dut.state); failures++; end
            checks++; if (ms_final_result !== 32'hCAFE_F00D) begin $display("FAIL stall%0d_result got=%h exp=cafef00d", i, ms_final_result); failures++; end
            checks++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b0) begin $display("FAIL stall%0d_hs got=%b/%b exp=1/0", i, ms_to_ws_valid, ms_allowin); failures++; end
        end
        cyc();
        ws_allowin = 1'b1;
        settle();
        checks++; if (ms_allowin !== 1'b1 || ms_final_result !== 32'hCAFE_F00D) begin $display("FAIL stall_release got=%b/%h exp=1/cafef00d", ms_allowin, ms_final_result); failures++; end
        cyc();
        settle();
        checks++; if (ms_to_ws_valid !== 1'b0 || dut.state !== 2'd0) begin $display("FAIL stall_done got=%b/%0d exp=0/0", ms_to_ws_valid, dut.state); failures++; end
    endtask

    task automatic test_flush_drop();
        cyc();
        idle_inputs();
        present(32'h0000_0500, LD_W, 32'h0000_1000, 1'b1);
        cyc();
        idle_inputs();
        wb_ex = 1'b1;
        cyc();
        idle_inputs();
        present(32'h0000_0600, LD_W, 32'h0000_2000, 1'b1);
        settle();
        checks++; if (dut.drop_cnt !== 2'd1) begin $display("FAIL flush_drop_inc got=%0d exp=1", dut.drop_cnt); failures++; end
        checks++; if (ms_to_ws_valid !== 1'b0) begin $display("FAIL flush_valid got=%b exp=0", ms_to_ws_valid); failures++; end
        cyc();
        idle_inputs();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hBAD0_BAD0;
        settle();
        checks++; if (ms_to_ws_valid !== 1'b0) begin $display("FAIL stale_ignored got=%b exp=0", ms_to_ws_valid); failures++; end
        cyc();
        idle_inputs();
        settle();
        checks++; if (dut.drop_cnt !== 2'd0) begin $display("FAIL flush_drop_dec got=%0d exp=0", dut.drop_cnt); failures++; end
        checks++; if (ms_to_ws_valid !== 1'b0) begin $display("FAIL next_waiting got=%b exp=0", ms_to_ws_valid); failures++; end
        cyc();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h600D_F00D;
        settle();
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h600D_F00D) begin $display("FAIL next_load got=%b/%h exp=1/600df00d", ms_to_ws_valid, ms_final_result); failures++; end
        checks++; if (ms_pc !== 32'h0000_0600) begin $display("FAIL next_pc got=%h exp=00000600", ms_pc); failures++; end
    endtask

    task automatic test_flush_with_dataok();
        cyc();
        idle_inputs();
        present(32'h0000_0700, LD_W, 32'h0000_1000, 1'b1);
        cyc();
        idle_inputs();
        wb_ex             = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BAD_0BAD;
        cyc();
        idle_inputs();
        settle();
        checks++; if (dut.drop_cnt !== 2'd0) begin $display("FAIL flushok_drop got=%0d exp=0", dut.drop_cnt); failures++; end
        checks++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1) begin $display("FAIL flushok_hs got=%b/%b exp=0/1", ms_to_ws_valid, ms_allowin); failures++; end
        cyc();
        present(32'h0000_0704, LD_HU, 32'h0000_1002, 1'b1);
        cyc();
        idle_inputs();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5A5A_0000;
        settle();
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h0000_5A5A) begin $display("FAIL flushok_next got=%b/%h exp=1/00005a5a", ms_to_ws_valid, ms_final_result); failures++; end
    endtask

    task automatic test_exception();
        cyc();
        idle_inputs();
        present(32'h0000_0800, 5'b00000, 32'h0000_0042, 1'b0);
        es_ex_zip = 87'h8;
        cyc();
        idle_inputs();
        present(32'h0000_0804, 5'b00000, 32'h0000_0043, 1'b0);
        es2ms_tlb_exc = 8'h04;
        settle();
        checks++; if (ms_ex !== 1'b1 || ms_rf_we !== 1'b0) begin $display("FAIL exzip_ex got=%b/%b exp=1/0", ms_ex, ms_rf_we); failures++; end
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_ex_zip !== 87'h8) begin $display("FAIL exzip_pass got=%b/%h exp=1/8", ms_to_ws_valid, ms_ex_zip); failures++; end
        cyc();
        idle_inputs();
        settle();
        checks++; if (ms_ex !== 1'b1 || ms2ws_tlb_exc !== 8'h04 || ms_rf_we !== 1'b0) begin $display("FAIL tlbexc got=%b/%h/%b exp=1/04/0", ms_ex, ms2ws_tlb_exc, ms_rf_we); failures++; end
        cyc();
        settle();
        checks++; if (ms_ex !== 1'b0) begin $display("FAIL ex_gated got=%b exp=0", ms_ex); failures++; end
    endtask

    task automatic test_back_to_back();
        cyc();
        idle_inputs();
        present(32'h0000_0900, LD_W, 32'h0000_3000, 1'b1);
        cyc();
        present(32'h0000_0904, LD_W, 32'h0000_3004, 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_2222;
        settle();
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h1111_2222 || ms_allowin !== 1'b1) begin $display("FAIL b2b_first got=%b/%h/%b exp=1/11112222/1", ms_to_ws_valid, ms_final_result, ms_allowin); failures++; end
        cyc();
        idle_inputs();
        settle();
        checks++; if (ms_to_ws_valid !== 1'b0 || ms_pc !== 32'h0000_0904) begin $display("FAIL b2b_wait got=%b/%h exp=0/00000904", ms_to_ws_valid, ms_pc); failures++; end
        cyc();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h3333_4444;
        settle();
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_final_result !== 32'h3333_4444) begin $display("FAIL b2b_second got=%b/%h exp=1/33334444", ms_to_ws_valid, ms_final_result); failures++; end
        cyc();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        cyc();
        present(32'h0000_0A00, LD_W, 32'h0000_1000, 1'b1);
        es_ex_zip     = 87'h1 << 40;
        es2ms_tlb_zip = 10'h3FF;
        cyc();
        idle_inputs();
        settle();
        checks++; if (dut.state !== 2'd1 || ms_pc !== 32'h0000_0A00) begin $display("FAIL areset_pre got=%0d/%h exp=1/00000a00", dut.state, ms_pc); failures++; end
        resetn = 1'b0;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0 || ms_rf_we !== 1'b0 || ms_fwd_valid !== 1'b0) begin $display("FAIL areset_ctl got=%b/%b/%b exp=0/0/0", ms_to_ws_valid, ms_rf_we, ms_fwd_valid); failures++; end
        checks++; if (ms_pc !== 32'h0 || ms_final_result !== 32'h0 || ms_rf_waddr !== 5'd0) begin $display("FAIL areset_data got=%h/%h/%0d exp=0/0/0", ms_pc, ms_final_result, ms_rf_waddr); failures++; end
        checks++; if (ms_ex_zip !== 87'h0 || ms2ws_tlb_zip !== 10'h0 || ms2ws_tlb_exc !== 8'h0) begin $display("FAIL areset_zip got=%h/%h/%h exp=0/0/0", ms_ex_zip, ms2ws_tlb_zip, ms2ws_tlb_exc); failures++; end
        checks++; if (dut.state !== 2'd0 || dut.drop_cnt !== 2'd0) begin $display("FAIL areset_fsm got=%0d/%0d exp=0/0", dut.state, dut.drop_cnt); failures++; end
        cyc();
        resetn = 1'b1;
        settle();
        checks++; if (ms_allowin !== 1'b1 || ms_to_ws_valid !== 1'b0) begin $display("FAIL areset_post got=%b/%b exp=1/0", ms_allowin, ms_to_ws_valid); failures++; end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_ext();
        test_wb_stall();
        test_flush_drop();
        test_flush_with_dataok();
        test_exception();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
